instruction_loader: RTL and testbench
=====================================

Name: instruction_loader

Overview:
Boot-time writer for the 32-entry instruction memory. It accepts a byte stream over a valid/ready handshake and assembles 32-bit instruction words, most-significant byte first. It writes each word into consecutive instruction-memory addresses starting at 0 and holds the CPU stalled while loading. Loading stops at a programmed word count, on a halt instruction, or when memory is full.

Parameters:
ADDR_WIDTH, 5, instruction memory address width; depth = 2^ADDR_WIDTH words.
DATA_WIDTH, 32, instruction word width; fixed at 32 (4 bytes per word).
HALT_OPCODE, 6'b111111, opcode (bits 31:26) that terminates loading after it is written.

Ports:
Clock  input  1  rising-edge clock.
Reset  input  1  asynchronous, active-low reset.
Start  input  1  one-cycle request to begin a load; sampled only in IDLE.
WordCount  input  ADDR_WIDTH+1  number of words to load; latched on the accepted Start.
ByteIn  input  8  stream byte.
ByteValid  input  1  ByteIn is valid.
ByteReady  output  1  loader accepts a byte this cycle.
WrEnable  output  1  instruction memory write strobe.
WrAddr  output  ADDR_WIDTH  instruction memory write address.
WrData  output  32  instruction word to write.
CpuHold  output  1  stalls the CPU and forces PC to 0 while high.
Busy  output  1  a load is in progress.
Done  output  1  level; the last load completed; cleared by the next accepted Start.
WordsLoaded  output  ADDR_WIDTH+1  number of words written by the current or last load.

Behaviour:
- Reset (async, Reset=0): state=IDLE. ByteReady, WrEnable, CpuHold, Busy and Done are 0. WrAddr, WrData and WordsLoaded are 0. Any partial word is discarded and no write is issued.
- FSM states are IDLE, RECV, WRITE, FINISH.
- IDLE:
  - ByteReady=0, Busy=0, CpuHold=0.
  - Start=1: latch target = min(WordCount, 2^ADDR_WIDTH); clear address, byte index, WordsLoaded and Done.
  - Next state is RECV if target != 0, else FINISH.
- RECV:
  - ByteReady=1, Busy=1, CpuHold=1.
  - A byte transfers when ByteValid && ByteReady. Assembly register shifts left 8 bits, new byte enters bits 7:0, byte index increments.
  - ByteValid=0 stalls indefinitely with no timeout; assembled bytes are held.
  - The transfer of byte index 3 moves the FSM to WRITE. Byte index wraps to 0.
- WRITE:
  - Lasts exactly one cycle. ByteReady=0.
  - WrEnable=1, WrAddr=current address, WrData=assembled word.
  - At the end of the cycle: address+1, WordsLoaded+1.
  - Next state is FINISH if the word's bits 31:26 == HALT_OPCODE, or WordsLoaded+1 == target, or address == 2^ADDR_WIDTH-1. Otherwise RECV.
  - The halt word itself is written.
- FINISH:
  - Lasts one cycle. Busy=1, CpuHold=1. Sets Done=1, then goes to IDLE.
  - CpuHold falls on the cycle after FINISH.
- Latency: the WrEnable pulse occurs in the cycle immediately after the 4th byte handshake. Maximum throughput is 1 word per 5 cycles.
- Start asserted while not in IDLE is ignored.
- WrAddr and WrData hold their last values when WrEnable=0. Consumers must qualify them with WrEnable.
- A byte offered during WRITE/FINISH/IDLE is not accepted (ByteReady=0). The sender must hold it.
- Address never wraps: loading terminates at the last address even if target is not reached.
- Reset mid-word or mid-write: immediate return to IDLE. Words already written stay in memory. Done=0.

Test Plan:
1. Start with WordCount=2; stream 00 C0 00 01, 00 C4 00 03 with ByteValid constant high. Required: WrEnable at addr 0 with 32'h00C00001, and at addr 1 with 32'h00C40003. Then Done=1, WordsLoaded=2, CpuHold falls 2 cycles after the 2nd write.
2. WordCount=5; third word is FC000000. Required: exactly 3 writes (addr 0-2), the last with data FC000000; Done=1, WordsLoaded=3; further bytes are not accepted (ByteReady=0).
3. WordCount=0. Required: no WrEnable, Busy high for 1 cycle, Done=1, WordsLoaded=0.
4. WordCount=40 with 32+ words streamed. Required: writes to addr 0..31 only, termination after addr 31, WordsLoaded=32, Done=1.
5. ByteValid toggled randomly, and Start pulsed during RECV. Required: words identical to a gap-free run, Start ignored, no extra writes.
6. Reset asserted after 2 bytes of word 1 (word 0 already written). Required: immediate return to IDLE, no write for word 1, all outputs 0; a new Start reloads from addr 0.

Source files
------------

// File: rtl/instruction_loader.sv
// Boot-time instruction memory loader: assembles a byte stream (MSB first) into
// 32-bit words and writes them to consecutive addresses while holding the CPU.
module instruction_loader #(
  parameter int              ADDR_WIDTH  = 5,
  parameter int              DATA_WIDTH  = 32,
  parameter logic [5:0]      HALT_OPCODE = 6'b111111
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  wr_enable,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, RECV, WRITE, FINISH} state_t;

  state_t                state;
  logic [ADDR_WIDTH:0]   target;
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            byte_idx;
  logic [DATA_WIDTH-9:0] asm_word;

  logic                  byte_fire;
  logic [ADDR_WIDTH:0]   start_target;
  logic [ADDR_WIDTH:0]   loaded_next;
  logic                  last_word;

  assign byte_fire    = byte_valid && byte_ready;
  assign start_target = (word_count > DEPTH_CNT) ? DEPTH_CNT : word_count;
  assign loaded_next  = words_loaded + 1'b1;
  // Evaluated in WRITE, where wr_data already holds the word being stored.
  assign last_word    = (wr_data[DATA_WIDTH-1 -: 6] == HALT_OPCODE) ||
                        (loaded_next == target) ||
                        (addr == LAST_ADDR);

  // NOTE: all state and outputs use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      target       <= '0;
      addr         <= '0;
      byte_idx     <= '0;
      asm_word     <= '0;
      byte_ready   <= 1'b0;
      wr_enable    <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      cpu_hold     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      words_loaded <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            target       <= start_target;
            addr         <= '0;
            byte_idx     <= '0;
            words_loaded <= '0;
            done         <= 1'b0;
            busy         <= 1'b1;
            cpu_hold     <= 1'b1;
            if (start_target != '0) begin
              state      <= RECV;
              byte_ready <= 1'b1;
            end else begin
              state      <= FINISH;
            end
          end
        end

        RECV: begin
          if (byte_fire) begin
            asm_word <= {asm_word[DATA_WIDTH-17:0], byte_in};
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == 2'd3) begin
              state      <= WRITE;
              byte_ready <= 1'b0;
              wr_enable  <= 1'b1;
              wr_addr    <= addr;
              wr_data    <= {asm_word, byte_in};
            end
          end
        end

        WRITE: begin
          wr_enable    <= 1'b0;
          words_loaded <= loaded_next;
          if (last_word) begin
            state <= FINISH;
          end else begin
            addr       <= addr + 1'b1;
            state      <= RECV;
            byte_ready <= 1'b1;
          end
        end

        FINISH: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: word assembly, termination causes,
// stalls, ignored start and mid-load reset.
module tb_instruction_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  word_count;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        wr_enable;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic [5:0]  words_loaded;

  int checks = 0;
  int errors = 0;

  logic [4:0]  wq_addr[$];
  logic [31:0] wq_data[$];

  instruction_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .word_count   (word_count),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .wr_enable    (wr_enable),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write log, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_enable) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no completion, required finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers a byte starting at a negedge; returns at the negedge after it transfers.
  task automatic send_byte(input logic [7:0] b);
    int n;
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) check("ready_timeout", {63'd0, byte_ready}, 64'd1);
    else @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic start_load(input logic [5:0] wc);
    start      = 1'b1;
    word_count = wc;
    @(negedge clk);
    start      = 1'b0;
  endtask

  function automatic logic [31:0] fill_word(input int i);
    logic [7:0] k;
    k = 8'(i);
    return {8'h10, k, 8'h20, ~k};
  endfunction

  initial begin
    logic        saw_ready;
    logic [31:0] t5 [3];
    int          g;

    rst_n = 1'b0; start = 1'b0; word_count = '0; byte_in = '0; byte_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_byte_ready", byte_ready, 0);
    check("rst_wr_enable", wr_enable, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_words_loaded", words_loaded, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: two words, gap-free stream
    start_load(6'd2);
    check("t1_recv_ready", byte_ready, 1);
    check("t1_recv_hold", cpu_hold, 1);
    check("t1_recv_busy", busy, 1);
    send_word(32'h00C00001);
    check("t1_w0_en", wr_enable, 1);
    check("t1_w0_addr", wr_addr, 0);
    check("t1_w0_data", wr_data, 32'h00C00001);
    check("t1_w0_ready", byte_ready, 0);
    send_word(32'h00C40003);
    byte_valid = 1'b0;
    check("t1_w1_en", wr_enable, 1);
    check("t1_w1_addr", wr_addr, 1);
    check("t1_w1_data", wr_data, 32'h00C40003);
    @(negedge clk);
    check("t1_fin_en", wr_enable, 0);
    check("t1_fin_hold", cpu_hold, 1);
    check("t1_fin_busy", busy, 1);
    check("t1_fin_done", done, 0);
    check("t1_hold_addr", wr_addr, 1);
    @(negedge clk);
    check("t1_idle_hold", cpu_hold, 0);
    check("t1_idle_busy", busy, 0);
    check("t1_done", done, 1);
    check("t1_loaded", words_loaded, 2);
    check("t1_nwrites", wq_addr.size(), 2);

    // Test 2: halt opcode ends the load after three words
    wq_addr.delete(); wq_data.delete();
    start_load(6'd5);
    check("t2_done_cleared", done, 0);
    send_word(32'h01020304);
    send_word(32'h05060708);
    send_word(32'hFC000000);
    check("t2_halt_en", wr_enable, 1);
    check("t2_halt_addr", wr_addr, 2);
    check("t2_halt_data", wr_data, 32'hFC000000);
    byte_in = 8'h55;
    saw_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      saw_ready |= byte_ready;
    end
    check("t2_no_accept", saw_ready, 0);
    byte_valid = 1'b0;
    check("t2_done", done, 1);
    check("t2_loaded", words_loaded, 3);
    check("t2_nwrites", wq_addr.size(), 3);

    // Test 3: zero word count
    wq_addr.delete(); wq_data.delete();
    start_load(6'd0);
    check("t3_fin_busy", busy, 1);
    check("t3_fin_ready", byte_ready, 0);
    check("t3_fin_done", done, 0);
    @(negedge clk);
    check("t3_busy_low", busy, 0);
    check("t3_done", done, 1);
    check("t3_loaded", words_loaded, 0);
    check("t3_nwrites", wq_addr.size(), 0);

    // Test 4: count beyond depth stops at the last address
    wq_addr.delete(); wq_data.delete();
    start_load(6'd40);
    for (int w = 0; w < 32; w++) send_word(fill_word(w));
    check("t4_last_addr", wr_addr, 31);
    saw_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      saw_ready |= byte_ready;
    end
    byte_valid = 1'b0;
    check("t4_no_accept", saw_ready, 0);
    check("t4_done", done, 1);
    check("t4_loaded", words_loaded, 32);
    check("t4_nwrites", wq_addr.size(), 32);
    for (int w = 0; w < 32 && w < wq_addr.size(); w++) begin
      check($sformatf("t4_addr%0d", w), wq_addr[w], 64'(w));
      check($sformatf("t4_data%0d", w), wq_data[w], fill_word(w));
    end

    // Test 5: random valid gaps and a start pulse during RECV
    wq_addr.delete(); wq_data.delete();
    t5[0] = 32'h12345678; t5[1] = 32'h9ABCDEF0; t5[2] = 32'h0F1E2D3C;
    start_load(6'd3);
    for (int w = 0; w < 3; w++) begin
      for (int b = 3; b >= 0; b--) begin
        send_byte(t5[w][b*8 +: 8]);
        byte_valid = 1'b0;
        if (w == 1 && b == 2) begin
          start      = 1'b1;
          word_count = 6'd7;
          @(negedge clk);
          start      = 1'b0;
        end
        g = $urandom_range(0, 3);
        repeat (g) @(negedge clk);
      end
    end
    repeat (6) @(negedge clk);
    check("t5_nwrites", wq_addr.size(), 3);
    for (int w = 0; w < 3 && w < wq_addr.size(); w++) begin
      check($sformatf("t5_addr%0d", w), wq_addr[w], 64'(w));
      check($sformatf("t5_data%0d", w), wq_data[w], t5[w]);
    end
    check("t5_done", done, 1);
    check("t5_loaded", words_loaded, 3);

    // Test 6: reset mid-word, then reload from address 0
    wq_addr.delete(); wq_data.delete();
    start_load(6'd4);
    send_word(32'h0A0B0C0D);
    send_byte(8'h11);
    send_byte(8'h22);
    byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_ready", byte_ready, 0);
    check("t6_en", wr_enable, 0);
    check("t6_addr", wr_addr, 0);
    check("t6_data", wr_data, 0);
    check("t6_hold", cpu_hold, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_loaded", words_loaded, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_nwrites", wq_addr.size(), 1);
    start_load(6'd1);
    send_word(32'h33445566);
    byte_valid = 1'b0;
    check("t6_re_en", wr_enable, 1);
    check("t6_re_addr", wr_addr, 0);
    check("t6_re_data", wr_data, 32'h33445566);
    repeat (2) @(negedge clk);
    check("t6_re_done", done, 1);
    check("t6_re_loaded", words_loaded, 1);
    check("t6_re_nwrites", wq_addr.size(), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
